// File: rtl/button_conditioner.sv
// Push-button front end: synchronises and debounces btn_raw, then derives
// press/release pulses, a long-press level and optional auto-repeat pulses.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 32
) (
    input  logic clk100M,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        LONG_HELD  = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   from_long_r;
    logic                   btn_level_r;
    logic                   press_pulse_r;
    logic                   release_pulse_r;
    logic                   long_press_r;
    logic                   repeat_pulse_r;

    assign sync_s        = sync_r[SYNC_STAGES-1];
    assign btn_level     = btn_level_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign long_press    = long_press_r;
    assign repeat_pulse  = repeat_pulse_r;

    // Metastability synchroniser for the asynchronous button input.
    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Debounce / hold-time FSM with registered outputs; cnt restarts on every state change.
    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= CNT_ZERO;
            from_long_r     <= 1'b0;
            btn_level_r     <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            long_press_r    <= 1'b0;
            repeat_pulse_r  <= 1'b0;
        end else begin
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            repeat_pulse_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (sync_s) begin
                        state_r <= DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (!sync_s) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == DB_LAST) begin
                        state_r       <= HELD;
                        cnt_r         <= CNT_ZERO;
                        press_pulse_r <= 1'b1;
                        btn_level_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync_s) begin
                        state_r     <= DB_RELEASE;
                        cnt_r       <= CNT_ZERO;
                        from_long_r <= 1'b0;
                    end else if (cnt_r == LONG_LAST) begin
                        state_r        <= LONG_HELD;
                        cnt_r          <= CNT_ZERO;
                        long_press_r   <= 1'b1;
                        repeat_pulse_r <= repeat_en;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                LONG_HELD: begin
                    if (!sync_s) begin
                        state_r     <= DB_RELEASE;
                        cnt_r       <= CNT_ZERO;
                        from_long_r <= 1'b1;
                    end else if (cnt_r == REP_LAST) begin
                        cnt_r          <= CNT_ZERO;
                        repeat_pulse_r <= repeat_en;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DB_RELEASE: begin
                    // A glitch returns to the hold state it came from, without pulses.
                    if (sync_s) begin
                        state_r <= from_long_r ? LONG_HELD : HELD;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == DB_LAST) begin
                        state_r         <= IDLE;
                        cnt_r           <= CNT_ZERO;
                        release_pulse_r <= 1'b1;
                        btn_level_r     <= 1'b0;
                        long_press_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= CNT_ZERO;
                    from_long_r  <= 1'b0;
                    btn_level_r  <= 1'b0;
                    long_press_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long/repeat times.
module tb_button_conditioner;

    logic clk100M;
    logic rst_n;
    logic btn_raw;
    logic repeat_en;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (10),
        .REPEAT_CYCLES  (3),
        .CNT_W          (8)
    ) dut (
        .clk100M      (clk100M),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .repeat_en    (repeat_en),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse)
    );

    initial clk100M = 1'b0;
    always #5 clk100M = ~clk100M;

    task automatic chk(input string tag, input string sig, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%b expected=%b t=%0t", tag, sig, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic lvl, input logic pr,
                           input logic rl, input logic lp, input logic rp);
        chk(tag, "btn_level",     btn_level,     lvl);
        chk(tag, "press_pulse",   press_pulse,   pr);
        chk(tag, "release_pulse", release_pulse, rl);
        chk(tag, "long_press",    long_press,    lp);
        chk(tag, "repeat_pulse",  repeat_pulse,  rp);
    endtask

    // Advance n clock edges, checking the expected outputs after each edge.
    task automatic run(input string tag, input int n, input logic lvl, input logic pr,
                       input logic rl, input logic lp, input logic rp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk100M);
            @(negedge clk100M);
            chk_all(tag, lvl, pr, rl, lp, rp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_raw   = 1'b0;
        repeat_en = 1'b0;
        @(negedge clk100M);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("reset_hold", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run("post_reset", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Clean press: press_pulse after edge 7
        btn_raw = 1'b1;
        run("press_wait", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("press_pulse", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("press_hold", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Release glitch of 2 cycles is rejected
        btn_raw = 1'b0;
        run("glitch_low", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        run("glitch_back", 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Real release: release_pulse 7 edges after the fall
        btn_raw = 1'b0;
        run("rel_wait", 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rel_pulse", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("rel_idle", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bounce rejection
        btn_raw = 1'b1;
        run("bounce", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b0;
        run("bounce", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b1;
        run("bounce", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_raw = 1'b0;
        run("bounce_settle", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long press with auto-repeat, held 30 cycles
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        run("lp_wait", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("lp_press", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("lp_held", 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("lp_entry", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run("lp_gap", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            run("lp_repeat", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        run("lp_gap", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        btn_raw = 1'b0;
        run("lp_fall_gap", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run("lp_last_repeat", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run("lp_rel_wait", 4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run("lp_release", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("lp_idle", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Repeat disabled after the 2nd repeat pulse
        btn_raw = 1'b1;
        run("rd_wait", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rd_press", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("rd_held", 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rd_entry", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run("rd_gap", 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run("rd_repeat2", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat_en = 1'b0;
        run("rd_quiet", 10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        btn_raw = 1'b0;
        run("rd_rel_wait", 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        run("rd_release", 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("rd_idle", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during LONG_HELD, button still held afterwards
        repeat_en = 1'b1;
        btn_raw   = 1'b1;
        run("rs_wait", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rs_press", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("rs_held", 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rs_entry", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        run("rs_long", 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all("rs_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rs_in_reset", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run("rs_rewait", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("rs_repress", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("rs_reheld", 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
